// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared sizes, reset values and helpers for the data memory arbiter
package data_memory_arbiter_pkg;
   localparam int ADDRESS_SIZE   = 16;
   localparam int DATA_SIZE      = 16;
   localparam int ARB_MAX_PORTS  = 8;
   localparam int RR_PTR_RESET   = 0;
   localparam int WAIT_CNT_RESET = 0;

   typedef enum logic [1:0] {
      OWNER_IDLE,
      OWNER_CORE,
      OWNER_EXT
   } owner_t;

   // A single-port arbiter still needs a 1-bit pointer to keep widths legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/data_memory_arbiter_rr_arbiter.sv
// rtl/data_memory_arbiter_rr_arbiter.sv - combinational rotate/priority/rotate-back round-robin picker
module rr_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int N = 2,
   localparam int IW = ptr_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);
   logic [N-1:0] rotated;
   logic [IW:0]  sum;
   logic         found;

   always_comb begin
      rotated = N'({req, req} >> ptr);
      found   = 1'b0;
      sum     = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && rotated[k]) begin
            found = 1'b1;
            sum   = (IW+1)'(k) + {1'b0, ptr};
         end
      end
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      gnt_idx = sum[IW-1:0];
      gnt     = '0;
      if (found) gnt[gnt_idx] = 1'b1;
   end
endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - shares the data memory: zero-wait core priority, round-robin external ports
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int N_EXT   = 2,
   parameter int ADDR_W  = ADDRESS_SIZE,
   parameter int DATA_W  = DATA_SIZE,
   parameter int TIMEOUT = 255
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      core_read,
   input  logic                      core_write,
   input  logic [ADDR_W-1:0]         core_address,
   input  logic [DATA_W-1:0]         core_data_out,
   output logic [DATA_W-1:0]         core_data_in,
   input  logic [N_EXT-1:0]          ext_req,
   input  logic [N_EXT-1:0]          ext_we,
   input  logic [N_EXT*ADDR_W-1:0]   ext_address,
   input  logic [N_EXT*DATA_W-1:0]   ext_wdata,
   output logic [N_EXT-1:0]          ext_gnt,
   output logic [N_EXT-1:0]          ext_rvalid,
   output logic [DATA_W-1:0]         ext_rdata,
   output logic [N_EXT-1:0]          ext_timeout,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [ADDR_W-1:0]         mem_address,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);
   localparam int IW = ptr_width(N_EXT);
   localparam int CW = $clog2(TIMEOUT + 1);

   owner_t           owner;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    arb_idx;
   logic [N_EXT-1:0] arb_gnt;
   logic [CW-1:0]    wait_cnt [N_EXT];

   rr_arbiter #(.N(N_EXT)) u_rr_arbiter (
      .req     (ext_req),
      .ptr     (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   always_comb begin
      owner = OWNER_IDLE;
      if (core_read || core_write) owner = OWNER_CORE;
      else if (|ext_req)           owner = OWNER_EXT;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      ext_gnt     = '0;
      case (owner)
         OWNER_CORE: begin
            mem_write   = core_write;
            mem_read    = core_read && !core_write;
            mem_address = core_address;
            mem_wdata   = core_data_out;
         end
         OWNER_EXT: begin
            mem_write   = ext_we[arb_idx];
            mem_read    = !ext_we[arb_idx];
            mem_address = ext_address[int'(arb_idx)*ADDR_W +: ADDR_W];
            mem_wdata   = ext_wdata[int'(arb_idx)*DATA_W +: DATA_W];
            ext_gnt     = reset ? arb_gnt : '0;
         end
         default: ;
      endcase
   end

   // The core has no stall input, so its load data is simply the raw memory output.
   assign core_data_in = mem_rdata;
   assign ext_rdata    = (|ext_rvalid) ? mem_rdata : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr      <= IW'(RR_PTR_RESET);
         ext_rvalid  <= '0;
         ext_timeout <= '0;
         for (int i = 0; i < N_EXT; i++) wait_cnt[i] <= CW'(WAIT_CNT_RESET);
      end else begin
         if (|ext_gnt) rr_ptr <= (int'(arb_idx) == N_EXT - 1) ? '0 : arb_idx + 1'b1;
         ext_rvalid <= ext_gnt & ~ext_we;
         for (int i = 0; i < N_EXT; i++) begin
            if (ext_gnt[i]) begin
               wait_cnt[i]    <= '0;
               ext_timeout[i] <= 1'b0;
            end else if (ext_req[i]) begin
               if (wait_cnt[i] != CW'(TIMEOUT)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
               if (wait_cnt[i] >= CW'(TIMEOUT - 1)) ext_timeout[i] <= 1'b1;
            end else begin
               wait_cnt[i] <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed and randomized checks of the data memory arbiter
module tb_data_memory_arbiter;
   localparam int N   = 2;
   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int TMO = 255;

   logic              clock = 1'b0;
   logic              reset;
   logic              core_read, core_write;
   logic [AW-1:0]     core_address;
   logic [DW-1:0]     core_data_out, core_data_in;
   logic [N-1:0]      ext_req, ext_we, ext_gnt, ext_rvalid, ext_timeout;
   logic [N*AW-1:0]   ext_address;
   logic [N*DW-1:0]   ext_wdata;
   logic [DW-1:0]     ext_rdata;
   logic              mem_read, mem_write;
   logic [AW-1:0]     mem_address;
   logic [DW-1:0]     mem_wdata, mem_rdata;

   logic [DW-1:0]     mem [256];
   logic              mem_ready = 1'b0;
   logic [DW-1:0]     shadow [int];
   int                n_vec = 0;
   int                n_err = 0;

   data_memory_arbiter #(.N_EXT(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset),
      .core_read(core_read), .core_write(core_write), .core_address(core_address),
      .core_data_out(core_data_out), .core_data_in(core_data_in),
      .ext_req(ext_req), .ext_we(ext_we), .ext_address(ext_address), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_timeout(ext_timeout),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem_rdata <= '0;
         mem_ready <= 1'b1;
      end else begin
         if (mem_write) mem[mem_address[7:0]] <= mem_wdata;
         if (mem_read)  mem_rdata <= mem[mem_address[7:0]];
      end
   end

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      core_read = 0; core_write = 0; core_address = '0; core_data_out = '0;
      ext_req = '0; ext_we = '0; ext_address = '0; ext_wdata = '0;
   endtask

   task automatic test_reset();
      reset = 0;
      idle_inputs();
      ext_req = 2'b11;
      ext_address = {16'h0031, 16'h0030};
      cyc(); #1;
      n_vec++; if (ext_gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", ext_gnt); end
      n_vec++; if (ext_rvalid !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", ext_rvalid); end
      n_vec++; if (ext_timeout !== 2'b00) begin n_err++; $display("FAIL reset_timeout: got %b want 00", ext_timeout); end
      n_vec++; if (mem_read !== 1'b1 || mem_address !== 16'h0030) begin
         n_err++; $display("FAIL reset_follow: got rd=%b addr=%h want rd=1 addr=0030", mem_read, mem_address); end
      idle_inputs();
      reset = 1;
      cyc();
   endtask

   task automatic test_core_priority();
      logic [AW-1:0] pa [3];
      logic [DW-1:0] pd [3];
      pa = '{16'h0010, 16'h0030, 16'h0031};
      pd = '{16'h1234, 16'h3000, 16'h3131};
      for (int i = 0; i < 3; i++) begin
         core_write = 1; core_address = pa[i]; core_data_out = pd[i];
         #1;
         n_vec++; if (mem_write !== 1'b1 || mem_wdata !== pd[i]) begin
            n_err++; $display("FAIL core_store: got wr=%b data=%h want wr=1 data=%h", mem_write, mem_wdata, pd[i]); end
         cyc();
      end
      idle_inputs();
      core_read = 1; core_address = 16'h0010;
      ext_req = 2'b11; ext_address = {16'h0031, 16'h0030};
      #1;
      n_vec++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h0010 || ext_gnt !== 2'b00) begin
         n_err++; $display("FAIL core_priority: got rd=%b wr=%b addr=%h gnt=%b want 1 0 0010 00",
                           mem_read, mem_write, mem_address, ext_gnt); end
      cyc();
      idle_inputs();
      #1;
      n_vec++; if (core_data_in !== 16'h1234) begin
         n_err++; $display("FAIL core_load_data: got %h want 1234", core_data_in); end
      cyc();
   endtask

   task automatic test_round_robin();
      logic [1:0]    g_exp [5];
      logic [1:0]    v_exp [5];
      logic [DW-1:0] d_exp [5];
      g_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
      v_exp = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
      d_exp = '{16'h0000, 16'h3000, 16'h3131, 16'h3000, 16'h3131};
      ext_we = 2'b00; ext_address = {16'h0031, 16'h0030};
      for (int k = 0; k < 5; k++) begin
         ext_req = (k == 4) ? 2'b00 : 2'b11;
         #1;
         n_vec++; if (ext_gnt !== g_exp[k]) begin
            n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, ext_gnt, g_exp[k]); end
         n_vec++; if (ext_rvalid !== v_exp[k] || ext_rdata !== d_exp[k]) begin
            n_err++; $display("FAIL rr_rvalid[%0d]: got %b/%h want %b/%h", k, ext_rvalid, ext_rdata, v_exp[k], d_exp[k]); end
         cyc();
      end
      idle_inputs();
   endtask

   task automatic test_write_then_read();
      ext_req = 2'b10; ext_we = 2'b10;
      ext_address = {16'h0020, 16'h0000}; ext_wdata = {16'hABCD, 16'h0000};
      #1;
      n_vec++; if (ext_gnt !== 2'b10 || mem_write !== 1'b1 || mem_address !== 16'h0020 || mem_wdata !== 16'hABCD) begin
         n_err++; $display("FAIL ext_write: got gnt=%b wr=%b addr=%h data=%h want 10 1 0020 abcd",
                           ext_gnt, mem_write, mem_address, mem_wdata); end
      cyc();
      ext_req = 2'b01; ext_we = 2'b00; ext_address = {16'h0000, 16'h0020};
      #1;
      n_vec++; if (ext_gnt !== 2'b01 || mem_read !== 1'b1) begin
         n_err++; $display("FAIL ext_read_gnt: got gnt=%b rd=%b want 01 1", ext_gnt, mem_read); end
      cyc();
      idle_inputs();
      core_read = 1; core_address = 16'h0010;
      #1;
      n_vec++; if (ext_rvalid !== 2'b01 || ext_rdata !== 16'hABCD) begin
         n_err++; $display("FAIL ext_read_data: got %b/%h want 01/abcd", ext_rvalid, ext_rdata); end
      cyc();
      idle_inputs();
      #1;
      n_vec++; if (core_data_in !== 16'h1234 || ext_rvalid !== 2'b00 || ext_rdata !== 16'h0000) begin
         n_err++; $display("FAIL core_after_ext: got core=%h rv=%b rd=%h want 1234 00 0000",
                           core_data_in, ext_rvalid, ext_rdata); end
      cyc();
   endtask

   task automatic test_both_rw();
      core_read = 1; core_write = 1; core_address = 16'h0040; core_data_out = 16'h5555;
      #1;
      n_vec++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 16'h5555) begin
         n_err++; $display("FAIL both_rw: got wr=%b rd=%b data=%h want 1 0 5555", mem_write, mem_read, mem_wdata); end
      cyc();
      idle_inputs();
      #1;
      n_vec++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== '0 || mem_wdata !== '0) begin
         n_err++; $display("FAIL idle: got rd=%b wr=%b addr=%h data=%h want all 0", mem_read, mem_write, mem_address, mem_wdata); end
      cyc();
   endtask

   task automatic test_starvation();
      logic [1:0] t_exp;
      core_read = 1; core_address = 16'h0010;
      ext_req = 2'b01; ext_we = 2'b00; ext_address = '0;
      for (int k = 0; k < 300; k++) begin
         #1;
         t_exp = {1'b0, (k >= TMO)};
         n_vec++; if (ext_gnt !== 2'b00 || ext_timeout !== t_exp) begin
            n_err++; $display("FAIL starve[%0d]: got gnt=%b tmo=%b want 00 %b", k, ext_gnt, ext_timeout, t_exp); end
         cyc();
      end
      core_read = 0;
      #1;
      n_vec++; if (ext_gnt !== 2'b01 || ext_timeout !== 2'b01) begin
         n_err++; $display("FAIL starve_grant: got gnt=%b tmo=%b want 01 01", ext_gnt, ext_timeout); end
      cyc();
      idle_inputs();
      #1;
      n_vec++; if (ext_timeout !== 2'b00) begin
         n_err++; $display("FAIL starve_clear: got %b want 00", ext_timeout); end
      cyc();
   endtask

   task automatic test_reset_mid_read();
      ext_req = 2'b01; ext_we = 2'b00; ext_address = {16'h0000, 16'h0010};
      #1;
      n_vec++; if (ext_gnt !== 2'b01) begin n_err++; $display("FAIL mid_gnt: got %b want 01", ext_gnt); end
      #2 reset = 0;
      #1;
      n_vec++; if (ext_gnt !== 2'b00) begin n_err++; $display("FAIL mid_gnt_forced: got %b want 00", ext_gnt); end
      cyc();
      #1;
      n_vec++; if (ext_rvalid !== 2'b00 || ext_timeout !== 2'b00) begin
         n_err++; $display("FAIL mid_rvalid: got rv=%b tmo=%b want 00 00", ext_rvalid, ext_timeout); end
      reset = 1;
      ext_req = 2'b11; ext_address = {16'h0031, 16'h0030};
      #1;
      n_vec++; if (ext_gnt !== 2'b01) begin n_err++; $display("FAIL post_reset_gnt: got %b want 01", ext_gnt); end
      cyc();
      idle_inputs();
      #1;
      n_vec++; if (ext_rvalid !== 2'b01 || ext_rdata !== 16'h3000) begin
         n_err++; $display("FAIL post_reset_data: got %b/%h want 01/3000", ext_rvalid, ext_rdata); end
      cyc();
   endtask

   task automatic test_random();
      logic [N-1:0]  p_req, p_we, e_gnt, m_rvalid, m_tmo;
      logic [AW-1:0] p_addr [N];
      logic [DW-1:0] p_wd [N];
      int            m_wait [N];
      int            m_ptr, gi, j, r;
      logic          e_rd, e_wr, m_core_valid;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, rd_val, m_rdata, m_core_data, e_rdata;
      reset = 0; idle_inputs();
      cyc();
      reset = 1;
      p_req = '0; p_we = '0; m_rvalid = '0; m_tmo = '0; m_ptr = 0;
      m_core_valid = 0; m_rdata = '0; m_core_data = '0;
      for (int i = 0; i < N; i++) begin m_wait[i] = 0; p_addr[i] = '0; p_wd[i] = '0; end
      for (int c = 0; c < 1500; c++) begin
         r = $urandom_range(0, 9);
         core_read = (r < 2) || (r == 3);
         core_write = (r == 2) || (r == 3);
         core_address = 16'h0080 + 16'($urandom_range(0, 15));
         core_data_out = DW'($urandom);
         for (int i = 0; i < N; i++) begin
            if (!p_req[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  p_req[i] = 1; p_we[i] = 1'($urandom_range(0, 1));
                  p_addr[i] = 16'h0080 + 16'($urandom_range(0, 15)); p_wd[i] = DW'($urandom);
               end
            end else if ($urandom_range(0, 19) == 0) p_req[i] = 0;
            ext_req[i] = p_req[i]; ext_we[i] = p_we[i];
            ext_address[i*AW +: AW] = p_addr[i]; ext_wdata[i*DW +: DW] = p_wd[i];
         end
         #1;
         gi = -1; e_gnt = '0;
         e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
         if (core_read || core_write) begin
            e_wr = core_write; e_rd = !core_write; e_addr = core_address; e_wd = core_data_out;
         end else begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (gi < 0 && p_req[j]) gi = j;
            end
            if (gi >= 0) begin
               e_gnt[gi] = 1; e_wr = p_we[gi]; e_rd = !p_we[gi]; e_addr = p_addr[gi]; e_wd = p_wd[gi];
            end
         end
         e_rdata = (|m_rvalid) ? m_rdata : '0;
         n_vec++; if (mem_read !== e_rd || mem_write !== e_wr || mem_address !== e_addr || mem_wdata !== e_wd) begin
            n_err++; $display("FAIL rnd_mem[%0d]: got %b%b %h %h want %b%b %h %h", c,
                              mem_read, mem_write, mem_address, mem_wdata, e_rd, e_wr, e_addr, e_wd); end
         n_vec++; if (ext_gnt !== e_gnt || ext_rvalid !== m_rvalid || ext_rdata !== e_rdata) begin
            n_err++; $display("FAIL rnd_ext[%0d]: got gnt=%b rv=%b rd=%h want %b %b %h", c,
                              ext_gnt, ext_rvalid, ext_rdata, e_gnt, m_rvalid, e_rdata); end
         n_vec++; if (ext_timeout !== m_tmo) begin
            n_err++; $display("FAIL rnd_tmo[%0d]: got %b want %b", c, ext_timeout, m_tmo); end
         if (m_core_valid) begin
            n_vec++; if (core_data_in !== m_core_data) begin
               n_err++; $display("FAIL rnd_core[%0d]: got %h want %h", c, core_data_in, m_core_data); end
         end
         rd_val = shadow.exists(int'(e_addr)) ? shadow[int'(e_addr)] : '0;
         if (e_wr) shadow[int'(e_addr)] = e_wd;
         m_rvalid = (gi >= 0 && e_rd) ? e_gnt : '0;
         if (e_rd) m_rdata = rd_val;
         m_core_valid = core_read && !core_write;
         m_core_data = rd_val;
         for (int i = 0; i < N; i++) begin
            if (e_gnt[i]) begin m_wait[i] = 0; m_tmo[i] = 0; end
            else if (p_req[i]) begin
               m_wait[i] = (m_wait[i] + 1 > TMO) ? TMO : m_wait[i] + 1;
               if (m_wait[i] == TMO) m_tmo[i] = 1;
            end else m_wait[i] = 0;
         end
         if (gi >= 0) begin m_ptr = (gi + 1) % N; p_req[gi] = 0; end
         cyc();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_core_priority();
      test_round_robin();
      test_write_then_read();
      test_both_rw();
      test_starvation();
      test_reset_mid_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Shares the single-port synchronous data memory between the core's data port and N_EXT external requesters, such as a debug loader or DMA. The core has absolute, zero-wait priority because it has no memory stall input. External ports are served round-robin in the cycles where the core does not access memory. The block sits between the core's read/write/address/data_out/data_in pins and the data memory.

Parameters:
N_EXT, 2, number of external requester ports (1..8)
ADDR_W, `ADDRESS_SIZE, memory address width
DATA_W, `DATA_SIZE, memory data width
TIMEOUT, 255, wait-cycle threshold for the starvation flag (1..65535)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active low (0 = reset)
core_read  in  1  core load request, active 1
core_write  in  1  core store request, active 1
core_address  in  ADDR_W  core access address
core_data_out  in  DATA_W  core store data
core_data_in  out  DATA_W  load data to core
ext_req  in  N_EXT  per-port request, held until granted
ext_we  in  N_EXT  per-port write (1) / read (0)
ext_address  in  N_EXT*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
ext_wdata  in  N_EXT*DATA_W  packed write data
ext_gnt  out  N_EXT  one-hot grant, same cycle as the memory access
ext_rvalid  out  N_EXT  one-hot read-data-valid, one cycle after a read grant
ext_rdata  out  DATA_W  read data for the port flagged in ext_rvalid
ext_timeout  out  N_EXT  sticky starvation flag per port
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_read

Behaviour:
- Reset values: rr_ptr=0; ext_rvalid=0; wait counters=0; ext_timeout=0. Combinational outputs follow their inputs during reset; ext_gnt is forced to 0 while reset=0.
- Core owns the cycle when core_read|core_write. Memory request outputs equal the core inputs combinationally, ext_gnt=0.
- If core_read and core_write are both 1, write wins and mem_read=0.
- Otherwise the first requesting port at or after rr_ptr (mod N_EXT) is granted, combinationally. mem_write=ext_we[i]; mem_read=!ext_we[i]; address and wdata come from port i.
- After any external grant to port i, rr_ptr <= (i+1) mod N_EXT. rr_ptr holds in core cycles and idle cycles.
- Idle cycle (no requests): mem_read=mem_write=0; mem_address and mem_wdata = 0.
- core_data_in = mem_rdata at all times, so a core load issued in cycle t reads its data in t+1.
- ext_rvalid[i] is registered and is 1 in the cycle after port i receives a read grant. ext_rdata = mem_rdata when any rvalid is set, else 0.
- Back-to-back reads from the same port produce consecutive rvalid pulses.
- A core access in the cycle following an external read does not disturb that read's rdata.
- Starvation: wait_cnt[i] increments, saturating at TIMEOUT, in each cycle with ext_req[i]=1 and ext_gnt[i]=0. It resets to 0 on grant or when ext_req[i]=0.
- ext_timeout[i] sets when wait_cnt[i] reaches TIMEOUT and stays set until port i is granted.
- A requester must keep req/we/address/wdata stable until it sees gnt. Dropping req early is legal and drops the pending request.
- Reset asserted mid-operation clears any pending rvalid immediately; that read data is lost.

Decomposition:
- ARB_MAX_PORTS and the reset values of rr_ptr and wait_cnt go in architecture.vh next to ADDRESS_SIZE and DATA_SIZE.
- One sub-module, rr_arbiter: parameter N. Inputs req[N] and ptr; outputs one-hot gnt[N] and gnt_idx. Purely combinational rotate-priority-rotate-back.
- Muxing, rvalid pipeline and starvation counters stay in data_memory_arbiter.

Test Plan:
- Core load 0x10 in cycle 1 while ext_req=2'b11 -> mem_read=1, mem_address=0x10, ext_gnt=0; cycle 2: core_data_in = mem_rdata.
- Core idle, ext_req=2'b11, both reads, held for 4 cycles -> gnt sequence 01,10,01,10; rvalid follows the same sequence one cycle later.
- Port 1 writes 0xABCD to 0x20, then port 0 reads 0x20 -> read grant followed next cycle by rvalid=01 with ext_rdata=0xABCD.
- Core busy 300 consecutive cycles, ext_req[0]=1, TIMEOUT=255 -> ext_timeout[0] rises after cycle 255 and clears the cycle after the first grant.
- core_read=core_write=1 -> mem_write=1, mem_read=0.
- Reset pulsed low in the cycle between a port-0 read grant and its rvalid -> ext_rvalid stays 0, rr_ptr=0, ext_timeout=0; the first grant after reset goes to port 0.
